fnd_updown_counter: RTL and testbench
=====================================

// Module: fnd_updown_counter
// PURPOSE
//  Parametrised BCD up/down counter with multiplexed 7-segment (FND) display driver.
//  Generalises the fixed 4-digit 0..9999 counter:
//   - digit count, count limit, tick rate and scan rate are parameters
//   - adds run/stop, direction, synchronous clear and a wrap pulse.
//  Sits between the board clock/reset and the FND pins; usable as a top-level display sub-block.
// PARAMETERS
//  NUM_DIGITS  4            number of FND digits (1..8)
//  CLK_HZ      100_000_000  input clock frequency
//  TICK_HZ     10           count rate; tick period = CLK_HZ/TICK_HZ clocks
//  SCAN_HZ     1000         digit-scan rate; one digit per CLK_HZ/SCAN_HZ clocks
//  MAX_COUNT   9999         terminal value; must be < 10**NUM_DIGITS
// PORTS
//  clk       in   1             system clock, rising edge
//  rst       in   1             asynchronous reset, active-low (rst=0 resets)
//  run       in   1             1 = count on ticks, 0 = hold count and prescaler
//  dir       in   1             1 = up, 0 = down
//  clr       in   1             synchronous clear
//  bcd       out  4*NUM_DIGITS  current count, packed BCD; digit 0 = bits [3:0]
//  wrap      out  1             1-clk pulse on wrap-around
//  fnd_data  out  8             segments, active-low, {dp,g,f,e,d,c,b,a}
//  fnd_com   out  NUM_DIGITS    digit enables, active-low one-hot; [0] = least-significant digit
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset values: bcd=0, wrap=0, prescaler=0, scan index=0,
//    fnd_com=~1 (digit0 on), fnd_data=8'hC0 ("0", dp off).
//  - Prescaler:
//    - counts 0..CLK_HZ/TICK_HZ-1 while run=1, then wraps; tick = 1 clk at terminal value.
//    - run=0 freezes the prescaler.
//  - Counter: binary shadow and BCD digits update together, 1 clk after tick.
//    - Up:   MAX_COUNT -> 0, wrap=1.
//    - Down: 0 -> MAX_COUNT, wrap=1.
//    - Otherwise +/-1 with BCD digit carry/borrow (9->0 carries, 0->9 borrows).
//  - clr: next clk bcd=0 and prescaler=0; overrides a simultaneous tick; wrap stays 0.
//  - dir is sampled at the tick; a change between ticks has no effect until the next tick.
//  - wrap is registered, high exactly 1 clk, coincident with the wrapped bcd value.
//  - Scan: independent free-running divider (not gated by run/clr).
//    - index 0..NUM_DIGITS-1, wraps to 0.
//    - fnd_com = ~(1<<index).
//    - fnd_data = segment decode of digit[index], registered (same clk as fnd_com).
//    - Decode: 0..9 standard patterns, dp always 1 (off).
//  - Reset asserted mid-count: all state returns to reset values immediately; on release,
//    count restarts from 0 with a full tick period.
// CONFIGURATION
//  Macro: FND_LZB_EN (leading-zero blanking)
//  - Defined: a digit whose index > 0 that is 0 with all higher digits also 0 drives
//    fnd_data=8'hFF (blank). Its fnd_com is still asserted. Digit 0 is never blanked.
//  - Undefined: all digits always display, including leading zeros.
// TESTING  (bench params: CLK_HZ=1000, TICK_HZ=100 -> tick/10 clk, SCAN_HZ=250 -> 4 clk/digit, MAX_COUNT=23)
//  - Test 1: rst=0 mid-count, then release
//    -> bcd=0, fnd_com=4'b1110, fnd_data=8'hC0 while low; first increment 10 clk after release.
//  - Test 2: run=1, dir=1 for 24 ticks
//    -> bcd steps 0x0009->0x0010 (carry), reaches 0x0023, then 0x0000 with wrap=1 for one clk.
//  - Test 3: bcd=0, dir=0, one tick -> bcd=0x0023, wrap=1; next tick -> 0x0022, wrap=0.
//  - Test 4: bcd=0x0015; run=0 for 50 clk -> bcd stays 0x0015; clr coincident with tick
//    -> bcd=0x0000, wrap=0.
//  - Test 5: bcd=0x0017 -> fnd_com cycles 1110,1101,1011,0111 every 4 clk;
//    fnd_data = F8 ("7"), F9 ("1"), C0, C0.
//  - Test 6 (FND_LZB_EN): same as test 5 -> digits 2 and 3 show fnd_data=8'hFF;
//    at bcd=0 only digit0 shows C0.

Source files
------------

// File: rtl/fnd_updown_counter.sv
// BCD up/down counter with a multiplexed, active-low 7-segment (FND) driver.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_updown_counter #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TICK_HZ    = 10,
   parameter int unsigned SCAN_HZ    = 1000,
   parameter int unsigned MAX_COUNT  = 9999
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic                    dir,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    wrap,
   output logic [7:0]              fnd_data,
   output logic [NUM_DIGITS-1:0]   fnd_com
);

   localparam int unsigned TickDiv = CLK_HZ / TICK_HZ;
   localparam int unsigned ScanDiv = CLK_HZ / SCAN_HZ;
   localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam int unsigned ScanW   = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
   localparam int unsigned CntW    = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
   localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BcdW    = 4 * NUM_DIGITS;

   localparam logic [PreW-1:0]  PreMax  = PreW'(TickDiv - 1);
   localparam logic [ScanW-1:0] ScanMax = ScanW'(ScanDiv - 1);
   localparam logic [CntW-1:0]  CntMax  = CntW'(MAX_COUNT);
   localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

   function automatic logic [BcdW-1:0] to_bcd(input int unsigned n);
      int unsigned r;
      r = n;
      to_bcd = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         to_bcd[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endfunction

   localparam logic [BcdW-1:0] MaxBcd = to_bcd(MAX_COUNT);

   // Ripple +1 across digits: a 9 rolls to 0 and carries on.
   function automatic logic [BcdW-1:0] bcd_incr(input logic [BcdW-1:0] v);
      logic carry;
      carry = 1'b1;
      bcd_incr = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               bcd_incr[4*i +: 4] = 4'd0;
            end else begin
               bcd_incr[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   endfunction

   // Ripple -1 across digits: a 0 rolls to 9 and borrows on.
   function automatic logic [BcdW-1:0] bcd_decr(input logic [BcdW-1:0] v);
      logic borrow;
      borrow = 1'b1;
      bcd_decr = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               bcd_decr[4*i +: 4] = 4'd9;
            end else begin
               bcd_decr[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   endfunction

   // Active-low {dp,g,f,e,d,c,b,a}; dp always off.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   logic [PreW-1:0]       presc_q, presc_d;
   logic [CntW-1:0]       bin_q, bin_d;
   logic [BcdW-1:0]       bcd_q, bcd_d;
   logic                  wrap_q, wrap_d;
   logic [ScanW-1:0]      scan_cnt_q, scan_cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [7:0]            fnd_data_q, fnd_data_d;
   logic [NUM_DIGITS-1:0] fnd_com_q, fnd_com_d;
   logic                  tick;
   logic                  blank;
   logic [3:0]            cur_digit;

   // Prescaler and counter next state; clr wins over a coincident tick.
   always_comb begin
      presc_d = presc_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      wrap_d  = 1'b0;
      tick    = run && (presc_q == PreMax);
      if (clr) begin
         presc_d = '0;
         bin_d   = '0;
         bcd_d   = '0;
      end else if (run) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            if (dir) begin
               if (bin_q == CntMax) begin
                  bin_d  = '0;
                  bcd_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  bin_d = bin_q + 1'b1;
                  bcd_d = bcd_incr(bcd_q);
               end
            end else begin
               if (bin_q == '0) begin
                  bin_d  = CntMax;
                  bcd_d  = MaxBcd;
                  wrap_d = 1'b1;
               end else begin
                  bin_d = bin_q - 1'b1;
                  bcd_d = bcd_decr(bcd_q);
               end
            end
         end
      end
   end

   // Free-running scan divider and registered segment/common outputs.
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_cnt_q == ScanMax) begin
         scan_cnt_d = '0;
         idx_d      = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end
      cur_digit = bcd_q[{idx_q, 2'b00} +: 4];
      blank     = 1'b0;
`ifdef FND_LZB_EN
      // Blank when this and every higher digit is zero; digit 0 always shows.
      blank = (idx_q != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((i >= int'(idx_q)) && (bcd_q[4*i +: 4] != 4'd0)) begin
            blank = 1'b0;
         end
      end
`endif
      fnd_com_d  = ~(NUM_DIGITS'(1) << idx_q);
      fnd_data_d = blank ? 8'hFF : seg7(cur_digit);
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q    <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         wrap_q     <= 1'b0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         fnd_data_q <= 8'hC0;
         fnd_com_q  <= ~NUM_DIGITS'(1);
      end else begin
         presc_q    <= presc_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         wrap_q     <= wrap_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         fnd_data_q <= fnd_data_d;
         fnd_com_q  <= fnd_com_d;
      end
   end

   assign bcd      = bcd_q;
   assign wrap     = wrap_q;
   assign fnd_data = fnd_data_q;
   assign fnd_com  = fnd_com_q;

endmodule

// File: tb/tb_fnd_updown_counter.sv
// Scoreboard bench for fnd_updown_counter: an integer reference model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares them.
// Define FND_LZB_EN for both RTL and bench to cover leading-zero blanking.
module tb_fnd_updown_counter;

   localparam int unsigned NumDigits = 4;
   localparam int unsigned ClkHz     = 1000;
   localparam int unsigned TickHz    = 100;
   localparam int unsigned ScanHz    = 250;
   localparam int unsigned MaxCount  = 23;
   localparam int TickDiv = ClkHz / TickHz;
   localparam int ScanDiv = ClkHz / ScanHz;

   localparam logic [7:0] Seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      logic [15:0] bcd;
      logic        wrap;
      logic [3:0]  com;
      logic [7:0]  data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        run;
   logic        dir;
   logic        clr;
   logic [15:0] bcd;
   logic        wrap;
   logic [7:0]  fnd_data;
   logic [3:0]  fnd_com;

   fnd_updown_counter #(
      .NUM_DIGITS (NumDigits),
      .CLK_HZ     (ClkHz),
      .TICK_HZ    (TickHz),
      .SCAN_HZ    (ScanHz),
      .MAX_COUNT  (MaxCount)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .dir      (dir),
      .clr      (clr),
      .bcd      (bcd),
      .wrap     (wrap),
      .fnd_data (fnd_data),
      .fnd_com  (fnd_com)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: plain integers.
   int m_count, m_presc, m_scan, m_idx;

   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [15:0] pack_bcd(input int c);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'((c / pow10(i)) % 10);
      return v;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.bcd  = 16'h0000;
      e.wrap = 1'b0;
      e.com  = 4'b1110;
      e.data = 8'hC0;
      return e;
   endfunction

   function automatic void model_reset();
      m_count = 0;
      m_presc = 0;
      m_scan  = 0;
      m_idx   = 0;
   endfunction

   // One clock edge of the model using the inputs held across that edge.
   function automatic exp_t model_step(input logic r, input logic d, input logic c);
      exp_t e;
      int   dig;
      dig    = (m_count / pow10(m_idx)) % 10;
      e.com  = ~(4'b0001 << m_idx);
      e.data = Seg[dig];
`ifdef FND_LZB_EN
      if (m_idx > 0 && m_count < pow10(m_idx)) e.data = 8'hFF;
`endif
      if (m_scan == ScanDiv - 1) begin
         m_scan = 0;
         m_idx  = (m_idx + 1) % NumDigits;
      end else begin
         m_scan++;
      end
      e.wrap = 1'b0;
      if (c) begin
         m_count = 0;
         m_presc = 0;
      end else if (r) begin
         if (m_presc == TickDiv - 1) begin
            m_presc = 0;
            if (d) begin
               if (m_count == MaxCount) begin m_count = 0; e.wrap = 1'b1; end
               else m_count++;
            end else begin
               if (m_count == 0) begin m_count = MaxCount; e.wrap = 1'b1; end
               else m_count--;
            end
         end else begin
            m_presc++;
         end
      end
      e.bcd = pack_bcd(m_count);
      return e;
   endfunction

   // Advance one clock; predict the post-edge outputs; return 1 time unit after the edge.
   task automatic cycle();
      @(posedge clk);
      if (!rst) begin
         model_reset();
         sb.push_back(reset_exp());
      end else begin
         sb.push_back(model_step(run, dir, clr));
      end
      #1;
   endtask

   // Assert reset between edges; the DUT clears immediately, so the prediction for
   // the edge just taken is replaced by reset values.
   task automatic pulse_reset(input int n);
      rst = 1'b0;
      if (sb.size() > 0) sb[sb.size() - 1] = reset_exp();
      model_reset();
      repeat (n) cycle();
      rst = 1'b1;
   endtask

   task automatic wait_count(input int target);
      for (int k = 0; k < 2000; k++) begin
         if (m_count == target) return;
         cycle();
      end
      checks++;
      errors++;
      $display("FAIL wait_count timeout got %0d want %0d", m_count, target);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at %0t got %h want %h", name, $time, act, want);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare it on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("bcd", bcd, e.bcd);
            check("wrap", {15'd0, wrap}, {15'd0, e.wrap});
            check("fnd_com", {12'd0, fnd_com}, {12'd0, e.com});
            check("fnd_data", {8'd0, fnd_data}, {8'd0, e.data});
         end
      end
   end

   initial begin
      rst = 1'b1;
      run = 1'b0;
      dir = 1'b1;
      clr = 1'b0;
      model_reset();
      #2 rst = 1'b0;
      repeat (3) cycle();
      rst = 1'b1;
      run = 1'b1;

      // Reset mid-count, then restart with a full tick period.
      repeat (35) cycle();
      pulse_reset(3);
      repeat (12) cycle();

      // Count up through the digit carry and the MAX_COUNT wrap.
      repeat (24 * TickDiv) cycle();

      // Count down through zero.
      wait_count(0);
      dir = 1'b0;
      repeat (2 * TickDiv + 2) cycle();

      // Hold while stopped, then clear coincident with a tick.
      dir = 1'b1;
      wait_count(15);
      run = 1'b0;
      repeat (50) cycle();
      run = 1'b1;
      for (int k = 0; k < 20 && m_presc != TickDiv - 1; k++) cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;

      // Display scan at a two-digit value and at zero.
      wait_count(17);
      run = 1'b0;
      repeat (4 * ScanDiv * NumDigits) cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      repeat (2 * ScanDiv * NumDigits) cycle();

      // Randomised run/dir/clr with occasional asynchronous reset.
      for (int k = 0; k < 3000; k++) begin
         run = ($urandom_range(3) != 0);
         if ($urandom_range(15) == 0) dir = ~dir;
         clr = ($urandom_range(199) == 0);
         if ($urandom_range(999) == 0) pulse_reset(2);
         else cycle();
      end

      clr = 1'b0;
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("sb_drain", 16'(sb.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
